ripple_count_sampler: RTL and testbench

- Consumes the 4-bit q3..q0 outputs of the ripple counter and brings them into the synchronous clk domain.
- Filters ripple transients and extends the count with wrap-tracked high bits.
- Flags skipped counts and raises a sticky compare-match interrupt.
- Sits directly downstream of the ripple counter; feeds system-side logic that cannot tolerate asynchronous, glitching count bits.

---
 rtl/ripple_count_sampler.sv | 124 ++++++++++++
 tb/tb_ripple_count_sampler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// Brings the asynchronous 4-bit ripple count into the clk domain, rejects ripple
// transients, extends the count with wrap-tracked high bits and flags skips/matches.
module ripple_count_sampler #(
   parameter int EXT_W         = 4,
   parameter int STABLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         cnt_in,
   input  logic [EXT_W+3:0]   match_val,
   input  logic               match_en,
   input  logic               irq_clr,
   output logic [EXT_W+3:0]   count_out,
   output logic               count_valid,
   output logic               wrap_pulse,
   output logic               skip_err,
   output logic               match_irq
);

   localparam logic [2:0]       STAB_MAX = 3'(STABLE_CYCLES);
   localparam logic [EXT_W-1:0] EXT_ONE  = EXT_W'(1'b1);

   logic [3:0]       s1_r;
   logic [3:0]       s2_r;
   logic [3:0]       s3_r;
   logic [2:0]       stab_cnt_r;
   logic [3:0]       acc_r;
   logic [EXT_W-1:0] ext_r;

   logic [2:0]       stab_next_s;
   logic [3:0]       acc_inc_s;
   logic             accept_s;
   logic             wrap_s;
   logic             skip_s;
   logic             match_set_s;

   assign count_out = {ext_r, acc_r};

   // Acceptance fires on the edge where the stability count reaches its target,
   // so a value must sit unchanged at s2 for STABLE_CYCLES+1 edges.
   always_comb begin
      stab_next_s = 3'd0;
      acc_inc_s   = acc_r + 4'd1;
      if (s2_r == s3_r) begin
         if (stab_cnt_r >= STAB_MAX) begin
            stab_next_s = STAB_MAX;
         end else begin
            stab_next_s = stab_cnt_r + 3'd1;
         end
      end else begin
         stab_next_s = 3'd0;
      end
      accept_s    = (stab_next_s == STAB_MAX) && (s2_r != acc_r);
      wrap_s      = accept_s && (s2_r < acc_r);
      skip_s      = accept_s && (s2_r != acc_inc_s);
      match_set_s = count_valid && match_en && (count_out == match_val);
   end

   // Two-flop synchronizer plus a third stage used only for stability compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_r <= 4'd0;
         s2_r <= 4'd0;
         s3_r <= 4'd0;
      end else begin
         s1_r <= cnt_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Stability window counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stab_cnt_r <= 3'd0;
      end else begin
         stab_cnt_r <= stab_next_s;
      end
   end

   // Accepted low nibble and wrap-extended high bits; ext overflows silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= 4'd0;
         ext_r <= '0;
      end else if (accept_s) begin
         acc_r <= s2_r;
         if (wrap_s) begin
            ext_r <= ext_r + EXT_ONE;
         end
      end
   end

   // Single-cycle update and wrap strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_valid <= 1'b0;
         wrap_pulse  <= 1'b0;
      end else begin
         count_valid <= accept_s;
         wrap_pulse  <= wrap_s;
      end
   end

   // Sticky flags: a set in the same cycle as irq_clr wins over the clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skip_err  <= 1'b0;
         match_irq <= 1'b0;
      end else begin
         if (skip_s) begin
            skip_err <= 1'b1;
         end else if (irq_clr) begin
            skip_err <= 1'b0;
         end
         if (match_set_s) begin
            match_irq <= 1'b1;
         end else if (irq_clr) begin
            match_irq <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: directed table, corner sequences and random
// stimulus checked each cycle against a sample-window reference model.
module tb_ripple_count_sampler;

   localparam int EXT_W = 4;
   localparam int S     = 2;
   localparam int HN    = S + 3;

   logic             clk;
   logic             reset;
   logic [3:0]       cnt_in;
   logic [EXT_W+3:0] match_val;
   logic             match_en;
   logic             irq_clr;
   logic [EXT_W+3:0] count_out;
   logic             count_valid;
   logic             wrap_pulse;
   logic             skip_err;
   logic             match_irq;

   int checks = 0;
   int errors = 0;

   // reference model state: extended count as an integer plus sample history
   int         m_cnt;
   bit         m_cv, m_wrap, m_skip, m_irq;
   logic [3:0] hist [0:HN-1];

   typedef struct {
      logic [3:0] v;
      int         hold_n;
      logic [7:0] exp_cnt;
      int         exp_pulses;
      int         exp_wraps;
   } vec_t;
   vec_t tbl [15];

   ripple_count_sampler #(.EXT_W(EXT_W), .STABLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .match_val(match_val),
      .match_en(match_en), .irq_clr(irq_clr), .count_out(count_out),
      .count_valid(count_valid), .wrap_pulse(wrap_pulse), .skip_err(skip_err),
      .match_irq(match_irq));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_cv = 0; m_wrap = 0; m_skip = 0; m_irq = 0;
      for (int j = 0; j < HN; j++) hist[j] = 4'd0;
   endtask

   // A value is accepted once the last S+1 samples reaching s2 all equal it
   // and it differs from the currently accepted nibble.
   task automatic model_edge();
      logic [3:0] v;
      bit ok, set_m, set_k;
      int o;
      if (!reset) begin
         model_reset();
         return;
      end
      set_m = m_cv && match_en && (m_cnt == int'(match_val));
      v  = hist[1];
      ok = 1;
      for (int j = 1; j <= S + 1; j++) if (hist[j] != v) ok = 0;
      o = m_cnt % 16;
      if (int'(v) == o) ok = 0;
      set_k  = ok && (int'(v) != (o + 1) % 16);
      m_cv   = ok;
      m_wrap = ok && (int'(v) < o);
      if (ok) m_cnt = ((m_cnt / 16 + ((int'(v) < o) ? 1 : 0)) % (1 << EXT_W)) * 16 + int'(v);
      m_irq  = set_m ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
      m_skip = set_k ? 1'b1 : (irq_clr ? 1'b0 : m_skip);
      for (int j = HN - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = cnt_in;
   endtask

   task automatic compare_all();
      chk("count_out",   32'(count_out),   32'(m_cnt));
      chk("count_valid", 32'(count_valid), 32'(m_cv));
      chk("wrap_pulse",  32'(wrap_pulse),  32'(m_wrap));
      chk("skip_err",    32'(skip_err),    32'(m_skip));
      chk("match_irq",   32'(match_irq),   32'(m_irq));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic hold(input int n, output int pulses, output int wraps);
      pulses = 0;
      wraps  = 0;
      repeat (n) begin
         tick();
         pulses += int'(count_valid);
         wraps  += int'(wrap_pulse);
      end
   endtask

   // asserts reset between edges, checks the asynchronous clear, releases after two edges
   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_count_out", 32'(count_out), 32'd0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int p, w, seen, len;
      reset = 1'b0; cnt_in = 4'd0; match_val = '0; match_en = 1'b0; irq_clr = 1'b0;
      model_reset();
      for (int i = 0; i < 14; i++) begin
         tbl[i].v = 4'(i + 2); tbl[i].hold_n = 8; tbl[i].exp_cnt = 8'(i + 2);
         tbl[i].exp_pulses = 1; tbl[i].exp_wraps = 0;
      end
      tbl[14].v = 4'd0; tbl[14].hold_n = 8; tbl[14].exp_cnt = 8'h10;
      tbl[14].exp_pulses = 1; tbl[14].exp_wraps = 1;

      // reset state and idle with zero input
      @(posedge clk); #1;
      do_reset();
      hold(10, p, w);
      chk("idle_pulses", 32'(p), 32'd0);
      chk("idle_count", 32'(count_out), 32'd0);
      chk("idle_flags", 32'({skip_err, match_irq, wrap_pulse}), 32'd0);

      // 0->1 latency: valid visible exactly after edge k+4
      cnt_in = 4'd1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("latency_cv_%0d", i), 32'(count_valid), (i == 4) ? 32'd1 : 32'd0);
      end
      chk("step1_count", 32'(count_out), 32'h01);
      chk("step1_skip", 32'(skip_err), 32'd0);

      // clean increments through wrap
      for (int i = 0; i < 15; i++) begin
         cnt_in = tbl[i].v;
         hold(tbl[i].hold_n, p, w);
         chk($sformatf("tbl%0d_count", i), 32'(count_out), 32'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d_pulses", i), 32'(p), 32'(tbl[i].exp_pulses));
         chk($sformatf("tbl%0d_wraps", i), 32'(w), 32'(tbl[i].exp_wraps));
         chk($sformatf("tbl%0d_skip", i), 32'(skip_err), 32'd0);
      end

      // ripple glitch 0111 -> 0110 -> 1000
      cnt_in = 4'd7;
      hold(8, p, w);
      chk("jump7_skip", 32'(skip_err), 32'd1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("skip_cleared", 32'(skip_err), 32'd0);
      cnt_in = 4'd6; tick();
      cnt_in = 4'd8;
      hold(8, p, w);
      chk("glitch_pulses", 32'(p), 32'd1);
      chk("glitch_count", 32'(count_out), 32'h18);
      chk("glitch_skip", 32'(skip_err), 32'd0);

      // compare-match, sticky, clear, and clear colliding with a new set
      match_en = 1'b1; match_val = 8'h1A;
      cnt_in = 4'd9;  hold(8, p, w);
      chk("match_before", 32'(match_irq), 32'd0);
      cnt_in = 4'hA;  hold(8, p, w);
      chk("match_set", 32'(match_irq), 32'd1);
      cnt_in = 4'hB;  hold(8, p, w);
      chk("match_sticky", 32'(match_irq), 32'd1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("match_clr", 32'(match_irq), 32'd0);
      match_val = 8'h1C; cnt_in = 4'hC;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick();
         if (count_valid) seen = 1;
      end
      chk("match_cv_seen", 32'(seen), 32'd1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("match_set_wins", 32'(match_irq), 32'd1);
      match_en = 1'b0;

      // direct jump after reset, then reset mid-window
      do_reset();
      cnt_in = 4'd3; hold(8, p, w);
      chk("jump3_count", 32'(count_out), 32'h03);
      chk("jump3_skip", 32'(skip_err), 32'd1);
      cnt_in = 4'd4; tick(); tick();
      do_reset();
      chk("midrst_flags", 32'({count_valid, wrap_pulse, skip_err, match_irq}), 32'd0);
      cnt_in = 4'd0; hold(10, p, w);
      chk("midrst_pulses", 32'(p), 32'd0);
      chk("midrst_count", 32'(count_out), 32'd0);

      // randomized stimulus against the model
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 2) == 0) cnt_in = cnt_in + 4'd1;
         else cnt_in = 4'($urandom_range(0, 15));
         match_en  = 1'($urandom_range(0, 1));
         match_val = ($urandom_range(0, 1) == 0) ? 8'(m_cnt + 1) : 8'($urandom_range(0, 255));
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            irq_clr = ($urandom_range(0, 7) == 0);
            tick();
         end
         irq_clr = 1'b0;
         if (n == 60) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
